// File: rtl/tile_sched_pkg.sv
// Shared types for the tile scheduler: layer-type codes, FSM state type and the tile command record.
// The command record widths match the scheduler's default CH_W/DIM_W parameters.
package tile_sched_pkg;

  localparam int TS_CH_W  = 11;
  localparam int TS_DIM_W = 8;

  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_DW  = 2'd1;
  localparam logic [1:0] LT_STD = 2'd2;
  localparam logic [1:0] LT_LIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TS_DIM_W-1:0] row_base;
    logic [TS_DIM_W-1:0] row_len;
    logic [TS_CH_W-1:0]  k_base;
    logic [TS_DIM_W-1:0] k_len;
    logic [TS_CH_W-1:0]  d_base;
    logic [TS_DIM_W-1:0] d_len;
    logic                first_d;
    logic                last_d;
  } tile_cmd_t;

endpackage

// File: rtl/tile_len_clip.sv
// Clipped tile length: min(step, total - base), unsigned, never wraps below zero.
module tile_len_clip #(
  parameter int TW = 11,
  parameter int SW = 8
) (
  input  logic [SW-1:0] i_step,
  input  logic [TW-1:0] i_total,
  input  logic [TW-1:0] i_base,
  output logic [SW-1:0] o_len
);

  localparam int MW = (TW > SW) ? TW : SW;

  logic [MW-1:0] w_rem;
  logic [MW-1:0] w_step;

  assign w_rem  = (i_total > i_base) ? MW'(i_total - i_base) : '0;
  assign w_step = MW'(i_step);
  assign o_len  = (w_rem < w_step) ? SW'(w_rem) : i_step;

endmodule

// File: rtl/tile_scheduler.sv
// Walks a layer's tile loop nest (row outer, K middle, D inner) and issues one command per handshake.
// Optional perf counters are enabled with the TILE_SCHED_PERF_EN macro.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int CH_W  = TS_CH_W,
  parameter int DIM_W = TS_DIM_W,
  parameter int TN_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       layer_type_i,
  input  logic [CH_W-1:0]  in_D_i,
  input  logic [CH_W-1:0]  out_K_i,
  input  logic [DIM_W-1:0] tile_D_i,
  input  logic [DIM_W-1:0] tile_K_i,
  input  logic [DIM_W-1:0] out_R_i,
  input  logic [TN_W-1:0]  tile_n_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [DIM_W-1:0] row_base_o,
  output logic [DIM_W-1:0] row_len_o,
  output logic [CH_W-1:0]  k_base_o,
  output logic [DIM_W-1:0] k_len_o,
  output logic [CH_W-1:0]  d_base_o,
  output logic [DIM_W-1:0] d_len_o,
  output logic             first_d_o,
  output logic             last_d_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      tile_cnt_o,
  output logic [31:0]      stall_cnt_o
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       r_state;
  logic [1:0]       r_type;
  logic [CH_W-1:0]  r_in_d;
  logic [CH_W-1:0]  r_out_k;
  logic [DIM_W-1:0] r_tile_d;
  logic [DIM_W-1:0] r_tile_k;
  logic [DIM_W-1:0] r_out_r;
  logic [TN_W-1:0]  r_tile_n;
  logic [DIM_W-1:0] r_rs;
  logic [DIM_W-1:0] r_row;
  logic [CH_W-1:0]  r_k;
  logic [CH_W-1:0]  r_d;

  logic             w_is_dw;
  logic [DIM_W-1:0] w_rs_calc;
  logic [DIM_W-1:0] w_row_len;
  logic [DIM_W-1:0] w_k_len;
  logic [DIM_W-1:0] w_d_len_raw;
  logic [CH_W-1:0]  w_d_base;
  logic [DIM_W-1:0] w_d_len;
  logic [DIM_W:0]   w_row_end;
  logic [CH_W:0]    w_k_end;
  logic [CH_W:0]    w_d_end;
  logic             w_row_last;
  logic             w_k_last;
  logic             w_d_last;
  logic             w_valid;
  logic             w_hs;
  logic             w_start;
  logic             w_empty;
  tile_cmd_t        w_cmd;
  tile_cmd_t        w_cmd_out;

  assign w_is_dw = (r_type == LT_DW);
  assign w_valid = (r_state == S_ISSUE);
  assign w_hs    = w_valid & tile_ready_i;
  assign w_start = (r_state == S_IDLE) & start_i;
  assign w_empty = (r_in_d == '0) | (r_out_k == '0) | (r_out_r == '0);

  // Row step: tile_n clamped into [1, out_R]
  always_comb begin
    w_rs_calc = r_tile_n[DIM_W-1:0];
    if (r_tile_n == '0) begin
      w_rs_calc = DIM_W'(1);
    end else if (r_tile_n > TN_W'(r_out_r)) begin
      w_rs_calc = r_out_r;
    end
  end

  tile_len_clip #(.TW(DIM_W), .SW(DIM_W)) u_row_clip (
    .i_step  (r_rs),
    .i_total (r_out_r),
    .i_base  (r_row),
    .o_len   (w_row_len)
  );

  tile_len_clip #(.TW(CH_W), .SW(DIM_W)) u_k_clip (
    .i_step  (r_tile_k),
    .i_total (r_out_k),
    .i_base  (r_k),
    .o_len   (w_k_len)
  );

  tile_len_clip #(.TW(CH_W), .SW(DIM_W)) u_d_clip (
    .i_step  (r_tile_d),
    .i_total (r_in_d),
    .i_base  (r_d),
    .o_len   (w_d_len_raw)
  );

  // Depthwise layers collapse the D loop onto the K tile
  assign w_d_base = w_is_dw ? r_k : r_d;
  assign w_d_len  = w_is_dw ? w_k_len : w_d_len_raw;

  assign w_row_end  = {1'b0, r_row} + {1'b0, w_row_len};
  assign w_k_end    = {1'b0, r_k} + (CH_W+1)'(w_k_len);
  assign w_d_end    = {1'b0, r_d} + (CH_W+1)'(w_d_len_raw);
  assign w_row_last = (w_row_end >= {1'b0, r_out_r});
  assign w_k_last   = (w_k_end >= {1'b0, r_out_k});
  assign w_d_last   = w_is_dw | (w_d_end >= {1'b0, r_in_d});

  always_comb begin
    w_cmd          = '0;
    w_cmd.row_base = r_row;
    w_cmd.row_len  = w_row_len;
    w_cmd.k_base   = r_k;
    w_cmd.k_len    = w_k_len;
    w_cmd.d_base   = w_d_base;
    w_cmd.d_len    = w_d_len;
    w_cmd.first_d  = w_is_dw | (r_d == '0);
    w_cmd.last_d   = w_is_dw | (w_d_end == {1'b0, r_in_d});
  end

  assign w_cmd_out = w_valid ? w_cmd : '0;

  assign tile_valid_o = w_valid;
  assign row_base_o   = w_cmd_out.row_base;
  assign row_len_o    = w_cmd_out.row_len;
  assign k_base_o     = w_cmd_out.k_base;
  assign k_len_o      = w_cmd_out.k_len;
  assign d_base_o     = w_cmd_out.d_base;
  assign d_len_o      = w_cmd_out.d_len;
  assign first_d_o    = w_cmd_out.first_d;
  assign last_d_o     = w_cmd_out.last_d;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_type   <= '0;
      r_in_d   <= '0;
      r_out_k  <= '0;
      r_tile_d <= '0;
      r_tile_k <= '0;
      r_out_r  <= '0;
      r_tile_n <= '0;
      r_rs     <= '0;
      r_row    <= '0;
      r_k      <= '0;
      r_d      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_type   <= layer_type_i;
            r_in_d   <= in_D_i;
            r_out_k  <= out_K_i;
            r_tile_d <= (tile_D_i == '0) ? DIM_W'(1) : tile_D_i;
            r_tile_k <= (tile_K_i == '0) ? DIM_W'(1) : tile_K_i;
            r_out_r  <= out_R_i;
            r_tile_n <= tile_n_i;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rs    <= w_rs_calc;
          r_row   <= '0;
          r_k     <= '0;
          r_d     <= '0;
          r_state <= w_empty ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          if (w_hs) begin
            if (w_d_last) begin
              r_d <= '0;
              if (w_k_last) begin
                r_k   <= '0;
                r_row <= r_row + r_rs;
                if (w_row_last) begin
                  r_state <= S_DONE;
                end
              end else begin
                r_k <= r_k + CH_W'(r_tile_k);
              end
            end else begin
              r_d <= r_d + CH_W'(r_tile_d);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] r_tile_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating counters, cleared when a new layer is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_tile_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_hs && (r_tile_cnt != '1)) begin
        r_tile_cnt <= r_tile_cnt + 32'd1;
      end
      if (w_valid && !tile_ready_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign tile_cnt_o  = r_tile_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  logic w_unused_start;
  assign w_unused_start = w_start;
  assign tile_cnt_o     = '0;
  assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: expected tiles are queued at start and popped on each handshake.
module tb_tile_scheduler;
  import tile_sched_pkg::*;

  localparam int CH_W  = 11;
  localparam int DIM_W = 8;
  localparam int TN_W  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [1:0]       layer_type_i = '0;
  logic [CH_W-1:0]  in_D_i = '0;
  logic [CH_W-1:0]  out_K_i = '0;
  logic [DIM_W-1:0] tile_D_i = '0;
  logic [DIM_W-1:0] tile_K_i = '0;
  logic [DIM_W-1:0] out_R_i = '0;
  logic [TN_W-1:0]  tile_n_i = '0;
  logic             tile_ready_i = 1'b1;
  logic             tile_valid_o;
  logic [DIM_W-1:0] row_base_o;
  logic [DIM_W-1:0] row_len_o;
  logic [CH_W-1:0]  k_base_o;
  logic [DIM_W-1:0] k_len_o;
  logic [CH_W-1:0]  d_base_o;
  logic [DIM_W-1:0] d_len_o;
  logic             first_d_o;
  logic             last_d_o;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      tile_cnt_o;
  logic [31:0]      stall_cnt_o;

  tile_scheduler #(.CH_W(CH_W), .DIM_W(DIM_W), .TN_W(TN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .layer_type_i (layer_type_i),
    .in_D_i       (in_D_i),
    .out_K_i      (out_K_i),
    .tile_D_i     (tile_D_i),
    .tile_K_i     (tile_K_i),
    .out_R_i      (out_R_i),
    .tile_n_i     (tile_n_i),
    .tile_valid_o (tile_valid_o),
    .tile_ready_i (tile_ready_i),
    .row_base_o   (row_base_o),
    .row_len_o    (row_len_o),
    .k_base_o     (k_base_o),
    .k_len_o      (k_len_o),
    .d_base_o     (d_base_o),
    .d_len_o      (d_len_o),
    .first_d_o    (first_d_o),
    .last_d_o     (last_d_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .tile_cnt_o   (tile_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          valid_seen = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  bit          chk_gap = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int rb, input int rl, input int kb, input int kl,
                                       input int db, input int dl, input bit f, input bit l);
    return {8'd0, 8'(rb), 8'(rl), 11'(kb), 8'(kl), 11'(db), 8'(dl), f, l};
  endfunction

  function automatic logic [63:0] cur_pack();
    return pack(int'(row_base_o), int'(row_len_o), int'(k_base_o), int'(k_len_o),
                int'(d_base_o), int'(d_len_o), first_d_o, last_d_o);
  endfunction

  // Reference loop nest producing the expected command sequence
  task automatic push_layer(input logic [1:0] lt, input int ind, input int outk, input int td,
                            input int tk, input int outr, input int tn);
    int rs, rl, kl, dl;
    if (td == 0) td = 1;
    if (tk == 0) tk = 1;
    rs = (tn == 0) ? 1 : ((tn > outr) ? outr : tn);
    if (ind == 0 || outk == 0 || outr == 0) return;
    for (int r = 0; r < outr; r += rs) begin
      rl = (outr - r < rs) ? outr - r : rs;
      for (int k = 0; k < outk; k += tk) begin
        kl = (outk - k < tk) ? outk - k : tk;
        if (lt == LT_DW) begin
          exp_q.push_back(pack(r, rl, k, kl, k, kl, 1'b1, 1'b1));
        end else begin
          for (int d = 0; d < ind; d += td) begin
            dl = (ind - d < td) ? ind - d : td;
            exp_q.push_back(pack(r, rl, k, kl, d, dl, d == 0, d + dl == ind));
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (tile_valid_o) valid_seen++;
      if (tile_valid_o && tile_ready_i) begin
        $display("[%0t] tile r=%0d+%0d k=%0d+%0d d=%0d+%0d first=%0b last=%0b", $time,
                 row_base_o, row_len_o, k_base_o, k_len_o, d_base_o, d_len_o, first_d_o, last_d_o);
        if (exp_q.size() == 0) check_val("extra_tile", cur_pack(), 64'h0);
        else check_val("tile", cur_pack(), exp_q.pop_front());
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        if (chk_gap) check_val("done_gap", 64'(cyc - last_hs_cyc), 64'd1);
      end
    end
  end

  task automatic run_layer(input logic [1:0] lt, input int ind, input int outk, input int td,
                           input int tk, input int outr, input int tn, input int stall_at,
                           input int exp_n);
    int  base_hs, vseen0;
    bit  got, stalled;
    @(posedge clk); #1;
    layer_type_i = lt;
    in_D_i       = CH_W'(ind);
    out_K_i      = CH_W'(outk);
    tile_D_i     = DIM_W'(td);
    tile_K_i     = DIM_W'(tk);
    out_R_i      = DIM_W'(outr);
    tile_n_i     = TN_W'(tn);
    start_i      = 1'b1;
    push_layer(lt, ind, outk, td, tk, outr, tn);
    base_hs = hs_cnt;
    vseen0  = valid_seen;
    chk_gap = (exp_n != 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    check_val("load_valid", tile_valid_o, 0);
    check_val("load_busy", busy_o, 1);
    got = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 0 && exp_n != 0) check_val("first_valid", tile_valid_o, 1);
      if (c == 0 && exp_n == 0) check_val("zero_done", done_o, 1);
      if (stall_at >= 0 && !stalled && (hs_cnt - base_hs) == stall_at) begin
        stalled = 1'b1;
        tile_ready_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
        end
        check_val("bp_fields", cur_pack(), exp_q[0]);
        check_val("bp_valid", tile_valid_o, 1);
        check_val("bp_no_adv", 64'(hs_cnt - base_hs), 64'(stall_at));
`ifdef TILE_SCHED_PERF_EN
        check_val("bp_stall_cnt", stall_cnt_o, 5);
`else
        check_val("bp_stall_cnt_off", stall_cnt_o, 0);
`endif
        tile_ready_i = 1'b1;
      end
      if (done_o) got = 1'b1;
    end
    check_val("done_seen", got, 1);
    check_val("tiles_issued", 64'(hs_cnt - base_hs), 64'(exp_n));
    check_val("queue_empty", 64'(exp_q.size()), 0);
    if (exp_n == 0) check_val("no_valid", 64'(valid_seen - vseen0), 0);
`ifdef TILE_SCHED_PERF_EN
    check_val("perf_tiles", tile_cnt_o, 64'(exp_n));
`else
    check_val("perf_tiles_off", tile_cnt_o, 0);
`endif
    @(posedge clk); #1;
    check_val("done_pulse", done_o, 0);
    check_val("idle_busy", busy_o, 0);
  endtask

  initial begin
    int base_hs, d0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", tile_valid_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_fields", cur_pack(), 0);
    check_val("rst_tile_cnt", tile_cnt_o, 0);
    check_val("rst_stall_cnt", stall_cnt_o, 0);
    rst_n = 1'b1;

    run_layer(LT_PW,  64, 64, 32, 32, 8, 4,   -1, 8);
    run_layer(LT_STD, 40, 16, 10, 16, 2, 2,   -1, 4);
    run_layer(LT_PW,  40, 16, 32, 16, 2, 2,   -1, 2);
    run_layer(LT_DW,  25, 25, 8,  10, 3, 0,   -1, 9);
    run_layer(LT_LIN, 7,  3,  4,  0,  5, 100, -1, 6);
    run_layer(LT_PW,  64, 64, 32, 32, 8, 4,   3,  8);
    run_layer(LT_PW,  64, 0,  32, 32, 8, 4,   -1, 0);

    // Abort a layer mid-issue with an asynchronous reset
    @(posedge clk); #1;
    layer_type_i = LT_PW;
    in_D_i = 11'd64; out_K_i = 11'd64; tile_D_i = 8'd32; tile_K_i = 8'd32;
    out_R_i = 8'd8; tile_n_i = 32'd4;
    start_i = 1'b1;
    push_layer(LT_PW, 64, 64, 32, 32, 8, 4);
    base_hs = hs_cnt;
    chk_gap = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 0; c < 100 && (hs_cnt - base_hs) < 2; c++) begin
      @(posedge clk); #1;
    end
    check_val("abort_pre_valid", tile_valid_o, 1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_valid", tile_valid_o, 0);
    check_val("abort_busy", busy_o, 0);
    check_val("abort_tile_cnt", tile_cnt_o, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_no_done", 64'(done_cnt - d0), 0);
    check_val("abort_done_o", done_o, 0);
    exp_q.delete();
    rst_n = 1'b1;

    run_layer(LT_PW, 64, 64, 32, 32, 8, 4, -1, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
